// File: rtl/mips_pkg.sv
// Shared MIPS-Lite types: instruction word, opcode map and the ID/EX payload.
package mips_pkg;

    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned OPCODE_WIDTH   = 6;

    typedef logic [DATA_WIDTH-1:0] Instr;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_ADD  = 6'h00,
        OP_SUB  = 6'h01,
        OP_AND  = 6'h02,
        OP_OR   = 6'h03,
        OP_XOR  = 6'h04,
        OP_SLT  = 6'h05,
        OP_ADDI = 6'h06,
        OP_SUBI = 6'h07,
        OP_ANDI = 6'h08,
        OP_ORI  = 6'h09,
        OP_XORI = 6'h0A,
        OP_SLTI = 6'h0B,
        OP_LDW  = 6'h0C,
        OP_STW  = 6'h0D,
        OP_BZ   = 6'h0E,
        OP_BEQ  = 6'h0F,
        OP_JR   = 6'h10,
        OP_HALT = 6'h11
    } opcode_e;

    localparam opcode_e OP_BRANCH_BZ  = OP_BZ;
    localparam opcode_e OP_BRANCH_BEQ = OP_BEQ;
    localparam opcode_e OP_BRANCH_JR  = OP_JR;
    localparam opcode_e OP_STOP       = OP_HALT;

    typedef struct packed {
        logic                      valid;
        opcode_e                   opcode;
        logic [DATA_WIDTH-1:0]     rs_val;
        logic [DATA_WIDTH-1:0]     rt_val;
        logic [DATA_WIDTH-1:0]     imm_sext;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      wr_en;
        logic                      is_load;
        logic                      is_store;
    } IdEx;

    function automatic logic is_rtype(input opcode_e op);
        return op <= OP_SLT;
    endfunction

    function automatic logic is_ialu(input opcode_e op);
        return (op >= OP_ADDI) && (op <= OP_SLTI);
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 2-read / 1-write register file; R0 is hardwired to zero, reads see same-cycle writes.
module mips_regfile
    import mips_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_a,
    output logic [DATA_WIDTH-1:0]     rd_data_a_c,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0]     rd_data_b_c,
    input  logic                      wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  wr_live;

    assign wr_live = wr_en && (wr_addr != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs <= '{default: '0};
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Write-first bypass so WB never needs to stall ID.
    always_comb begin
        rd_data_a_c = regs[rd_addr_a];
        rd_data_b_c = regs[rd_addr_b];
        if (wr_live && (wr_addr == rd_addr_a)) rd_data_a_c = wr_data;
        if (wr_live && (wr_addr == rd_addr_b)) rd_data_b_c = wr_data;
        if (rd_addr_a == '0) rd_data_a_c = '0;
        if (rd_addr_b == '0) rd_data_b_c = '0;
    end

endmodule

// File: rtl/instr_decode.sv
// ID stage: IF/ID register, register read, decode, RAW interlock, branch resolve, HALT freeze.
module instr_decode
    import mips_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned NUM_REGS      = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  Instr                      instruction,
    input  logic [ADDRESS_WIDTH-1:0]  pc,
    output logic                      is_taken,
    output logic [ADDRESS_WIDTH-1:0]  branch_addr,
    output logic                      fetch_stall,
    input  logic                      ex_wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      mem_wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
    input  logic                      wb_en,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    output IdEx                       id_ex,
    output logic                      halted,
    output logic                      illegal
);

    typedef enum logic {ST_RUN, ST_HALTED} state_e;

    state_e                     state, state_d;
    logic                       ifid_valid, ifid_valid_d;
    Instr                       ifid_instr, ifid_instr_d;
    logic [ADDRESS_WIDTH-1:0]   ifid_pc, ifid_pc_d;
    IdEx                        id_ex_d;
    logic                       halted_d, illegal_d;

    logic [OPCODE_WIDTH-1:0]    op_raw;
    opcode_e                    op;
    logic [REG_ADDR_WIDTH-1:0]  rs_f, rt_f, rd_f;
    logic [15:0]                imm_f;
    logic [DATA_WIDTH-1:0]      rs_val, rt_val;
    logic                       op_legal, uses_rs, uses_rt;
    logic                       rs_hit, rt_hit, raw_stall;
    logic [ADDRESS_WIDTH-1:0]   br_offset, br_target, br_dest;
    logic                       br_cond;
    IdEx                        dec;

    assign op_raw = ifid_instr[31:26];
    assign op     = opcode_e'(op_raw);
    assign rs_f   = ifid_instr[25:21];
    assign rt_f   = ifid_instr[20:16];
    assign rd_f   = ifid_instr[15:11];
    assign imm_f  = ifid_instr[15:0];

    mips_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
        .clk         (clk),
        .reset_n     (reset_n),
        .rd_addr_a   (rs_f),
        .rd_data_a_c (rs_val),
        .rd_addr_b   (rt_f),
        .rd_data_b_c (rt_val),
        .wr_en       (wb_en),
        .wr_addr     (wb_rd),
        .wr_data     (wb_data)
    );

    assign op_legal = (op_raw <= 6'(OP_HALT));
    assign uses_rs  = op_legal && (op != OP_HALT);
    assign uses_rt  = op_legal && (is_rtype(op) || (op == OP_STW) || (op == OP_BEQ));

    // R0 never interlocks; WB is covered by the write-first register file.
    assign rs_hit = (rs_f != '0) && ((ex_wr_en && (ex_rd == rs_f)) || (mem_wr_en && (mem_rd == rs_f)));
    assign rt_hit = (rt_f != '0) && ((ex_wr_en && (ex_rd == rt_f)) || (mem_wr_en && (mem_rd == rt_f)));
    assign raw_stall = ifid_valid && (state == ST_RUN) && ((uses_rs && rs_hit) || (uses_rt && rt_hit));

    assign br_offset = {{(ADDRESS_WIDTH-18){imm_f[15]}}, imm_f, 2'b00};
    assign br_target = ifid_pc + br_offset;

    // Decode of the IF/ID instruction into the ID/EX payload and branch decision.
    always_comb begin
        dec          = '0;
        dec.valid    = 1'b1;
        dec.opcode   = op;
        dec.rs_val   = rs_val;
        dec.rt_val   = rt_val;
        dec.imm_sext = {{(DATA_WIDTH-16){imm_f[15]}}, imm_f};
        dec.is_load  = (op == OP_LDW);
        dec.is_store = (op == OP_STW);
        dec.wr_en    = is_rtype(op) || is_ialu(op) || (op == OP_LDW);
        if (is_rtype(op))   dec.rd = rd_f;
        else if (dec.wr_en) dec.rd = rt_f;

        br_cond = 1'b0;
        br_dest = br_target;
        case (op)
            OP_BRANCH_BZ:  br_cond = (rs_val == '0);
            OP_BRANCH_BEQ: br_cond = (rs_val == rt_val);
            OP_BRANCH_JR: begin
                br_cond = 1'b1;
                br_dest = ADDRESS_WIDTH'(rs_val);
            end
            default: ;
        endcase
    end

    // Next-state and stage control: HALTED > stall > taken > normal.
    always_comb begin
        state_d      = state;
        ifid_valid_d = 1'b1;
        ifid_instr_d = instruction;
        ifid_pc_d    = pc;
        id_ex_d      = '0;
        halted_d     = halted;
        illegal_d    = illegal;
        fetch_stall  = 1'b0;
        is_taken     = 1'b0;
        branch_addr  = '0;
        case (state)
            ST_HALTED: begin
                fetch_stall  = 1'b1;
                ifid_valid_d = 1'b0;
                ifid_instr_d = ifid_instr;
                ifid_pc_d    = ifid_pc;
                halted_d     = 1'b1;
            end
            default: begin
                if (raw_stall) begin
                    fetch_stall  = 1'b1;
                    ifid_valid_d = ifid_valid;
                    ifid_instr_d = ifid_instr;
                    ifid_pc_d    = ifid_pc;
                end else if (ifid_valid) begin
                    if (!op_legal) begin
                        illegal_d = 1'b1;
                    end else begin
                        id_ex_d = dec;
                        if (op == OP_STOP) begin
                            state_d      = ST_HALTED;
                            halted_d     = 1'b1;
                            fetch_stall  = 1'b1;
                            ifid_valid_d = 1'b0;
                        end else if (br_cond) begin
                            is_taken     = 1'b1;
                            branch_addr  = br_dest;
                            ifid_valid_d = 1'b0;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_RUN;
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
            ifid_pc    <= '0;
            id_ex      <= '0;
            halted     <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            state      <= state_d;
            ifid_valid <= ifid_valid_d;
            ifid_instr <= ifid_instr_d;
            ifid_pc    <= ifid_pc_d;
            id_ex      <= id_ex_d;
            halted     <= halted_d;
            illegal    <= illegal_d;
        end
    end

endmodule

// File: tb/tb_instr_decode.sv
// Bench for instr_decode: directed vector table, then random traffic against a reference model.
module tb_instr_decode;
    import mips_pkg::*;

    logic        clk;
    logic        reset_n;
    Instr        instruction;
    logic [31:0] pc;
    logic        is_taken;
    logic [31:0] branch_addr;
    logic        fetch_stall;
    logic        ex_wr_en, mem_wr_en, wb_en;
    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic [31:0] wb_data;
    IdEx         id_ex;
    logic        halted, illegal;

    int checks = 0;
    int failures = 0;

    instr_decode #(.ADDRESS_WIDTH(32), .NUM_REGS(32)) dut (
        .clk(clk), .reset_n(reset_n), .instruction(instruction), .pc(pc),
        .is_taken(is_taken), .branch_addr(branch_addr), .fetch_stall(fetch_stall),
        .ex_wr_en(ex_wr_en), .ex_rd(ex_rd), .mem_wr_en(mem_wr_en), .mem_rd(mem_rd),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .id_ex(id_ex), .halted(halted), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic Instr enc_r(int op, int rs, int rt, int rd);
        return {6'(op), 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic Instr enc_i(int op, int rs, int rt, logic [15:0] imm);
        return {6'(op), 5'(rs), 5'(rt), imm};
    endfunction

    typedef struct {
        Instr        instr;
        logic [31:0] pc;
        logic        ex_we;  logic [4:0] ex_rd;
        logic        mem_we; logic [4:0] mem_rd;
        logic        wb_en;  logic [4:0] wb_rd; logic [31:0] wb_data;
        logic        tk;     logic [31:0] ba;   logic st;
        logic        vl;     logic [5:0]  op;   logic [4:0] rd; logic wr;
        logic [31:0] imm;    logic [31:0] rsv;  logic [31:0] rtv;
        logic        il;     logic ht;
    } vec_t;

    function automatic vec_t mk(Instr instr, logic [31:0] p,
                                logic exw, logic [4:0] exr, logic mw, logic [4:0] mr,
                                logic we, logic [4:0] wr_, logic [31:0] wd,
                                logic tk, logic [31:0] ba, logic st,
                                logic vl, logic [5:0] op, logic [4:0] rd, logic wr,
                                logic [31:0] imm, logic [31:0] rsv, logic [31:0] rtv,
                                logic il, logic ht);
        vec_t v;
        v.instr = instr; v.pc = p;
        v.ex_we = exw; v.ex_rd = exr; v.mem_we = mw; v.mem_rd = mr;
        v.wb_en = we; v.wb_rd = wr_; v.wb_data = wd;
        v.tk = tk; v.ba = ba; v.st = st;
        v.vl = vl; v.op = op; v.rd = rd; v.wr = wr;
        v.imm = imm; v.rsv = rsv; v.rtv = rtv; v.il = il; v.ht = ht;
        return v;
    endfunction

    // Reference model state: what sits in ID, architectural registers, sticky flags.
    logic        m_if_valid, n_if_valid;
    logic [31:0] m_if_instr, n_if_instr, m_if_pc, n_if_pc;
    logic [31:0] m_regs [32];
    logic        m_halted, n_halted, m_illegal, n_illegal;
    logic        e_taken, e_stall;
    logic [31:0] e_baddr;
    IdEx         e_idex;

    function automatic logic haz_reg(int r);
        return (r != 0) && ((ex_wr_en && int'(ex_rd) == r) || (mem_wr_en && int'(mem_rd) == r));
    endfunction

    function automatic logic [31:0] read_reg(int r);
        if (r == 0) return 32'd0;
        if (wb_en && int'(wb_rd) == r) return wb_data;
        return m_regs[r];
    endfunction

    task automatic model_reset();
        m_if_valid = 1'b0; m_if_instr = '0; m_if_pc = '0;
        m_halted = 1'b0; m_illegal = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
    endtask

    task automatic model_eval();
        int op, rs, rt, rdf, off;
        logic [31:0] rsv, rtv;
        logic legal, is_r, is_ia, writes, src_rs, src_rt, take;
        logic [15:0] imm;
        op  = int'(m_if_instr[31:26]);
        rs  = int'(m_if_instr[25:21]);
        rt  = int'(m_if_instr[20:16]);
        rdf = int'(m_if_instr[15:11]);
        imm = m_if_instr[15:0];
        rsv = read_reg(rs);
        rtv = read_reg(rt);
        legal  = (op <= 17);
        is_r   = (op <= 5);
        is_ia  = (op >= 6 && op <= 11);
        writes = is_r || is_ia || op == 12;
        src_rs = legal && op != 17;
        src_rt = is_r || op == 13 || op == 15;
        e_taken = 1'b0; e_baddr = '0; e_stall = 1'b0; e_idex = '0;
        n_if_valid = 1'b1; n_if_instr = instruction; n_if_pc = pc;
        n_halted = m_halted; n_illegal = m_illegal;
        if (m_halted) begin
            e_stall = 1'b1;
            n_if_valid = 1'b0; n_if_instr = m_if_instr; n_if_pc = m_if_pc;
        end else if (m_if_valid && ((src_rs && haz_reg(rs)) || (src_rt && haz_reg(rt)))) begin
            e_stall = 1'b1;
            n_if_valid = m_if_valid; n_if_instr = m_if_instr; n_if_pc = m_if_pc;
        end else if (m_if_valid) begin
            if (!legal) begin
                n_illegal = 1'b1;
            end else begin
                e_idex.valid    = 1'b1;
                e_idex.opcode   = opcode_e'(6'(op));
                e_idex.rs_val   = rsv;
                e_idex.rt_val   = rtv;
                e_idex.imm_sext = 32'(int'($signed(imm)));
                e_idex.wr_en    = writes;
                e_idex.rd       = is_r ? 5'(rdf) : (writes ? 5'(rt) : 5'd0);
                e_idex.is_load  = (op == 12);
                e_idex.is_store = (op == 13);
                if (op == 17) begin
                    n_halted = 1'b1; e_stall = 1'b1; n_if_valid = 1'b0;
                end else begin
                    take = (op == 14 && rsv == 0) || (op == 15 && rsv == rtv) || (op == 16);
                    off  = int'($signed(imm)) * 4;
                    if (take) begin
                        e_taken = 1'b1;
                        e_baddr = (op == 16) ? rsv : m_if_pc + 32'(off);
                        n_if_valid = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic model_commit();
        if (wb_en && wb_rd != 0) m_regs[wb_rd] = wb_data;
        m_if_valid = n_if_valid; m_if_instr = n_if_instr; m_if_pc = n_if_pc;
        m_halted = n_halted; m_illegal = n_illegal;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_idex"}, 128'(id_ex), 128'd0);
        chk({tag, "_halted"}, 128'(halted), 128'd0);
        chk({tag, "_illegal"}, 128'(illegal), 128'd0);
        chk({tag, "_taken"}, 128'(is_taken), 128'd0);
        chk({tag, "_baddr"}, 128'(branch_addr), 128'd0);
        chk({tag, "_stall"}, 128'(fetch_stall), 128'd0);
    endtask

    vec_t vecs[18];

    initial begin
        Instr addi1, bz, add4, beq, addi5, halt_i;
        int   iters;
        addi1  = enc_i(6, 0, 1, 16'd5);
        bz     = enc_i(14, 0, 0, 16'hFFFE);
        add4   = enc_r(0, 1, 2, 4);
        beq    = enc_i(15, 2, 3, 16'd4);
        addi5  = enc_i(6, 0, 5, 16'd1);
        halt_i = enc_i(17, 0, 0, 16'd0);
        //          instr                 pc     exw exr mw mr we wr wd    tk ba     st vl op     rd wr imm            rsv rtv il ht
        vecs[0]  = mk(addi1,              32'h00, 0, 0, 0, 0, 0, 0, 0,    0, 0,     0, 0, 6'h00, 0, 0, 0,             0, 0, 0, 0);
        vecs[1]  = mk(bz,                 32'h10, 0, 0, 0, 0, 0, 0, 0,    0, 0,     0, 1, 6'h06, 1, 1, 5,             0, 0, 0, 0);
        vecs[2]  = mk(add4,               32'h14, 0, 0, 0, 0, 0, 0, 0,    1, 32'h08,0, 1, 6'h0E, 0, 0, 32'hFFFFFFFE,0, 0, 0, 0);
        vecs[3]  = mk(enc_i(6,0,0,0),     32'h08, 0, 0, 0, 0, 1, 2, 7,    0, 0,     0, 0, 6'h00, 0, 0, 0,             0, 0, 0, 0);
        vecs[4]  = mk(beq,                32'h0C, 0, 0, 0, 0, 1, 3, 7,    0, 0,     0, 1, 6'h06, 0, 1, 0,             0, 0, 0, 0);
        vecs[5]  = mk(addi5,              32'h10, 0, 0, 0, 0, 0, 0, 0,    1, 32'h1C,0, 1, 6'h0F, 0, 0, 4,             7, 7, 0, 0);
        vecs[6]  = mk(beq,                32'h1C, 0, 0, 0, 0, 0, 0, 0,    0, 0,     0, 0, 6'h00, 0, 0, 0,             0, 0, 0, 0);
        vecs[7]  = mk(add4,               32'h20, 0, 0, 0, 0, 1, 3, 8,    0, 0,     0, 1, 6'h0F, 0, 0, 4,             7, 8, 0, 0);
        vecs[8]  = mk(addi5,              32'h24, 1, 2, 0, 0, 0, 0, 0,    0, 0,     1, 0, 6'h00, 0, 0, 0,             0, 0, 0, 0);
        vecs[9]  = mk(addi5,              32'h24, 1, 2, 0, 0, 0, 0, 0,    0, 0,     1, 0, 6'h00, 0, 0, 0,             0, 0, 0, 0);
        vecs[10] = mk(addi5,              32'h24, 0, 0, 1, 1, 0, 0, 0,    0, 0,     1, 0, 6'h00, 0, 0, 0,             0, 0, 0, 0);
        vecs[11] = mk(addi5,              32'h24, 1, 0, 0, 0, 0, 0, 0,    0, 0,     0, 1, 6'h00, 4, 1, 32'h2000,      0, 7, 0, 0);
        vecs[12] = mk(32'hFEEDDEAD,       32'h28, 1, 0, 1, 0, 0, 0, 0,    0, 0,     0, 1, 6'h06, 5, 1, 1,             0, 0, 0, 0);
        vecs[13] = mk(enc_i(6,0,6,2),     32'h2C, 0, 0, 0, 0, 0, 0, 0,    0, 0,     0, 0, 6'h00, 0, 0, 0,             0, 0, 1, 0);
        vecs[14] = mk(halt_i,             32'h30, 0, 0, 0, 0, 0, 0, 0,    0, 0,     0, 1, 6'h06, 6, 1, 2,             0, 0, 1, 0);
        vecs[15] = mk(enc_i(6,0,7,3),     32'h34, 0, 0, 0, 0, 0, 0, 0,    0, 0,     1, 1, 6'h11, 0, 0, 0,             0, 0, 1, 1);
        vecs[16] = mk(enc_i(6,0,7,3),     32'h34, 0, 0, 0, 0, 0, 0, 0,    0, 0,     1, 0, 6'h00, 0, 0, 0,             0, 0, 1, 1);
        vecs[17] = mk(enc_i(6,0,7,3),     32'h34, 0, 0, 0, 0, 0, 0, 0,    0, 0,     1, 0, 6'h00, 0, 0, 0,             0, 0, 1, 1);

        reset_n = 1'b0; instruction = addi1; pc = '0;
        ex_wr_en = 0; ex_rd = 0; mem_wr_en = 0; mem_rd = 0;
        wb_en = 0; wb_rd = 0; wb_data = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            instruction = vecs[i].instr; pc = vecs[i].pc;
            ex_wr_en = vecs[i].ex_we; ex_rd = vecs[i].ex_rd;
            mem_wr_en = vecs[i].mem_we; mem_rd = vecs[i].mem_rd;
            wb_en = vecs[i].wb_en; wb_rd = vecs[i].wb_rd; wb_data = vecs[i].wb_data;
            #1;
            chk({t, "_taken"}, 128'(is_taken), 128'(vecs[i].tk));
            if (vecs[i].tk) chk({t, "_baddr"}, 128'(branch_addr), 128'(vecs[i].ba));
            chk({t, "_stall"}, 128'(fetch_stall), 128'(vecs[i].st));
            chk({t, "_never_both"}, 128'(is_taken & fetch_stall), 128'd0);
            @(posedge clk);
            #1;
            chk({t, "_valid"}, 128'(id_ex.valid), 128'(vecs[i].vl));
            if (vecs[i].vl) begin
                chk({t, "_opcode"}, 128'(id_ex.opcode), 128'(vecs[i].op));
                chk({t, "_rd"}, 128'(id_ex.rd), 128'(vecs[i].rd));
                chk({t, "_wr_en"}, 128'(id_ex.wr_en), 128'(vecs[i].wr));
                chk({t, "_imm"}, 128'(id_ex.imm_sext), 128'(vecs[i].imm));
                chk({t, "_rs_val"}, 128'(id_ex.rs_val), 128'(vecs[i].rsv));
                chk({t, "_rt_val"}, 128'(id_ex.rt_val), 128'(vecs[i].rtv));
            end
            chk({t, "_illegal"}, 128'(illegal), 128'(vecs[i].il));
            chk({t, "_halted"}, 128'(halted), 128'(vecs[i].ht));
        end

        // Asynchronous reset while halted.
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("halt_reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();

        iters = 400;
        for (int i = 0; i < iters; i++) begin
            int k;
            k = int'($urandom_range(0, 19));
            if (k <= 16)
                instruction = enc_i(k, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                                    $urandom_range(0, 1) ? 16'($urandom_range(0, 8)) : 16'($urandom));
            else if (k <= 18)
                instruction = 32'hFEEDDEAD;
            else
                instruction = {6'($urandom_range(18, 63)), 26'($urandom)};
            if (i == iters - 12) instruction = halt_i;
            pc        = $urandom;
            ex_wr_en  = ($urandom_range(0, 3) == 0);
            ex_rd     = 5'($urandom_range(0, 3));
            mem_wr_en = ($urandom_range(0, 3) == 0);
            mem_rd    = 5'($urandom_range(0, 3));
            wb_en     = ($urandom_range(0, 1) == 1);
            wb_rd     = 5'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0:       wb_data = 32'd0;
                1:       wb_data = 32'd7;
                default: wb_data = $urandom;
            endcase
            #1;
            model_eval();
            chk("rnd_taken", 128'(is_taken), 128'(e_taken));
            if (e_taken) chk("rnd_baddr", 128'(branch_addr), 128'(e_baddr));
            chk("rnd_stall", 128'(fetch_stall), 128'(e_stall));
            @(posedge clk);
            #1;
            model_commit();
            chk("rnd_idex", 128'(id_ex), 128'(e_idex));
            chk("rnd_illegal", 128'(illegal), 128'(m_illegal));
            chk("rnd_halted", 128'(halted), 128'(m_halted));
        end

        // Asynchronous reset mid-run.
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("final_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_decode.md
# instr_decode

Second pipeline stage of the MIPS-Lite core; the consumer side of the fetch interface. It registers the fetched instruction and its `pc` in an IF/ID register, reads the 32×32 register file, and decodes the instruction into a registered ID/EX bundle. It resolves BZ/BEQ/JR in ID and drives `is_taken`/`branch_addr` back to fetch. It interlocks on RAW hazards, since the core has no forwarding, and freezes the front end on HALT.

## Interface
- `ADDRESS_WIDTH`, 32, PC/address width
- `NUM_REGS`, 32, architectural registers; R0 reads as 0, writes are ignored
- `clk` in 1, core clock
- `reset_n` in 1, asynchronous, active-low
- `instruction` in `Instr` (32), fetched word for `pc`
- `pc` in ADDRESS_WIDTH, address of `instruction`
- `is_taken` out 1, redirect fetch this cycle (combinational)
- `branch_addr` out ADDRESS_WIDTH, redirect target (combinational)
- `fetch_stall` out 1, fetch must hold `pc` this cycle
- `ex_wr_en`, `ex_rd` in 1/5, destination of the instruction in EX
- `mem_wr_en`, `mem_rd` in 1/5, destination of the instruction in MEM
- `wb_en`, `wb_rd`, `wb_data` in 1/5/32, register-file write port
- `id_ex` out `IdEx` struct: valid, opcode, rs_val, rt_val, imm_sext, rd, wr_en, is_load, is_store
- `halted` out 1, HALT has reached ID; sticky
- `illegal` out 1, an undefined opcode was decoded; sticky

## Operation
- Formats: opcode[31:26], rs[25:21], rt[20:16], then rd[15:11] (R-type) or imm[15:0] (I-type). Opcodes are 0x00–0x11 per `mips_pkg::opcode_e`.
- Destination:
  - R-type ALU ops write `rd`.
  - I-type ALU ops and LDW write `rt`.
  - STW, BZ, BEQ, JR and HALT set wr_en = 0.
- Sources:
  - rs for every opcode except HALT.
  - rt also for R-type, STW and BEQ.
- Hazard: stall when a used source ≠ 0 matches `ex_rd` with `ex_wr_en` set, or matches `mem_rd` with `mem_wr_en` set. WB does not stall, because the register file is write-first (same-cycle read returns `wb_data`).
- When stalled:
  - `fetch_stall` = 1.
  - IF/ID holds its contents.
  - ID/EX loads a bubble (valid = 0).
  - `is_taken` = 0.
- Branches, evaluated only when IF/ID is valid and there is no stall:
  - BZ is taken if R[rs] == 0.
  - BEQ is taken if R[rs] == R[rt].
  - JR is always taken.
  - Target for BZ/BEQ: `pc_id + (sext(imm) << 2)`, modulo 2^ADDRESS_WIDTH. `pc_id` is the branch's own pc.
  - Target for JR: R[rs].
- Taken branch:
  - IF/ID captures valid = 0 next edge, squashing the wrong-path instruction.
  - The branch itself still enters ID/EX with wr_en = 0.
- Illegal opcode (including the misaligned fill 0xFEEDDEAD, opcode 0x3F): sets `illegal`, enters ID/EX as a bubble, no redirect.
- State machine:
  - RUN → HALTED when a valid HALT is in IF/ID. HALT enters ID/EX once.
  - In HALTED:
    - `fetch_stall` = 1 permanently.
    - IF/ID is invalidated.
    - ID/EX issues bubbles.
    - `halted` = 1.
  - Only reset leaves HALTED.

## Timing
- Reset, asynchronous and active-low:
  - IF/ID.valid = 0 and ID/EX = all-zero (valid = 0).
  - Register file is zeroed.
  - State = RUN.
  - `halted` = 0 and `illegal` = 0.
  - Combinational outputs are therefore 0.
- Deasserting reset makes IF/ID load `pc` = 0 on the first rising edge.
- Latency: an instruction at fetch on edge N is in ID during N..N+1, and in ID/EX on edge N+1 (no stall).
- Taken-branch penalty is 1 bubble. `is_taken` and `fetch_stall` are never both 1.
- Priority: reset > HALTED > stall > taken > normal.
- A WB write and a read of the same register in the same cycle return new data. A write to R0 is dropped.
- Reset mid-stall or mid-branch returns everything to the reset values on the same cycle.

## Structure
- `mips_pkg` gains:
  - `opcode_e` enum.
  - `IdEx` struct.
  - `REG_ADDR_WIDTH` = 5.
  - The HALT/branch opcode constants.
- `Instr` is reused as-is.
- One sub-module: `mips_regfile`, with 2 read ports, 1 write port, write-first, async active-low clear.
- Hazard, branch and decode logic live in `instr_decode`; the state is a 2-value enum.

## Test plan
- Reset low for 2 cycles, then high; `instruction` = ADDI R1,R0,5 → all outputs 0 during reset; next edge `id_ex` = {valid 1, opcode ADDI, rd 1, imm_sext 5, wr_en 1}.
- BZ R0 at pc 0x10 with imm = −2 → `is_taken` = 1, `branch_addr` = 0x08; next cycle IF/ID.valid = 0.
- BEQ R2,R3, R2 = R3 = 7 preset via WB → taken; set R3 = 8 → `is_taken` = 0, `branch_addr` ignored.
- ADD R4,R1,R2 with `ex_wr_en` = 1, `ex_rd` = 2 → `fetch_stall` = 1 and ID/EX bubble; the stall clears when EX moves on; an R0 match never stalls.
- Misaligned `instruction` = 0xFEEDDEAD → `illegal` = 1 (sticky), ID/EX bubble, no redirect.
- HALT in ID → `halted` = 1 and `fetch_stall` = 1 on every subsequent cycle; ID/EX valid once then 0; reset clears both.
